// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Defines the branch table entry layout and the reset PC.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    // Tag is held at full width; bits above the live tag stay zero.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] tag;
        logic            taken;
        logic [XLEN-1:0] target;
    } bht_entry_t;

endpackage

// File: rtl/fetch_bht.sv
// Direct-mapped 1-bit branch history / target table.
// Combinational lookup, synchronous write, async clear of valid bits.
module fetch_bht
    import fetch_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] rd_pc,
    output logic        rd_hit,
    output logic        rd_taken,
    output logic [31:0] rd_target,
    input  logic        wr_en,
    input  logic [31:0] wr_pc,
    input  logic        wr_taken,
    input  logic [31:0] wr_target
);

    localparam int IDX = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    bht_entry_t         mem [ENTRIES];
    bht_entry_t         rd_entry;
    logic [IDX-1:0]     rd_idx;
    logic [IDX-1:0]     wr_idx;
    logic [XLEN-1:0]    rd_tag;
    logic [XLEN-1:0]    wr_tag;
    logic               unused_lsb;

    assign rd_idx = rd_pc[IDX+1:2];
    assign wr_idx = wr_pc[IDX+1:2];
    assign rd_tag = rd_pc >> (IDX + 2);
    assign wr_tag = wr_pc >> (IDX + 2);
    assign unused_lsb = ^{rd_pc[1:0], wr_pc[1:0]};

    // Read the indexed entry and qualify it with its valid bit.
    always_comb begin
        rd_entry       = mem[rd_idx];
        rd_entry.valid = valid_q[rd_idx];
        rd_hit         = rd_entry.valid & (rd_entry.tag == rd_tag);
        rd_taken       = rd_hit & rd_entry.taken;
        rd_target      = rd_hit ? rd_entry.target : '0;
    end

    // Valid bits clear on reset; a resolve allocates its entry.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Entry payload; target is kept when the branch went not-taken.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_idx].valid <= 1'b1;
            mem[wr_idx].tag   <= wr_tag;
            mem[wr_idx].taken <= wr_taken;
            if (wr_taken) begin
                mem[wr_idx].target <= wr_target;
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC, branch prediction, mispredict redirect.
// Optional FETCH_CTRL_PERF_EN adds branch/mispredict counters.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          BHT_ENTRIES = 64,
    parameter logic [31:0] RESET_PC    = fetch_pkg::RESET_PC
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall_fetch,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_branch,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pred_target,
    output logic [31:0] o_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    output logic        o_stall_decode,
    output logic        o_flush_decode,
`ifdef FETCH_CTRL_PERF_EN
    output logic [31:0] o_branch_cnt,
    output logic [31:0] o_mispred_cnt,
`endif
    output logic        o_flush_execute
);

    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] redirect_pc;
    logic        resolve;
    logic        mispredict;
    logic        pred_hit;

    fetch_bht #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .rd_pc     (pc_q),
        .rd_hit    (pred_hit),
        .rd_taken  (o_pred_taken),
        .rd_target (o_pred_target),
        .wr_en     (resolve),
        .wr_pc     (i_ex_pc),
        .wr_taken  (i_ex_taken),
        .wr_target (i_ex_target)
    );

    // Resolve EX outcome and choose the next fetch address.
    always_comb begin
        resolve     = i_ex_valid & i_ex_is_branch;
        mispredict  = resolve &
                      ((i_ex_taken != i_ex_pred_taken) |
                       (i_ex_taken & i_ex_pred_taken &
                        (i_ex_target != i_ex_pred_target)));
        redirect_pc = i_ex_taken ? i_ex_target
                                 : i_ex_pc + 32'(INSTR_BYTES);
        pc_next     = pc_q + 32'(INSTR_BYTES);
        if (mispredict) begin
            pc_next = redirect_pc;
        end else if (i_stall_fetch) begin
            pc_next = pc_q;
        end else if (o_pred_taken) begin
            pc_next = o_pred_target;
        end
    end

    // Program counter register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    assign o_pc            = pc_q;
    assign o_flush_decode  = mispredict;
    assign o_flush_execute = mispredict;
    // Memory applies stall ahead of flush, so drop stall on redirect.
    assign o_stall_decode  = i_stall_fetch & ~mispredict;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispred_cnt_q;

    // Count every resolving cycle and every mispredict.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (resolve) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (mispredict) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign o_branch_cnt  = branch_cnt_q;
    assign o_mispred_cnt = mispred_cnt_q;
`else
    logic unused_hit;
    assign unused_hit = pred_hit;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus
// randomized traffic against a table-level reference model.
module tb_fetch_ctrl;

    localparam int N = 64;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_stall_fetch;
    logic        i_ex_valid;
    logic        i_ex_is_branch;
    logic [31:0] i_ex_pc;
    logic        i_ex_taken;
    logic [31:0] i_ex_target;
    logic        i_ex_pred_taken;
    logic [31:0] i_ex_pred_target;
    logic [31:0] o_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        o_stall_decode;
    logic        o_flush_decode;
    logic        o_flush_execute;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] o_branch_cnt;
    logic [31:0] o_mispred_cnt;
`endif

    int n_tests = 0;
    int n_fail = 0;

    fetch_ctrl #(
        .BHT_ENTRIES (N),
        .RESET_PC    (32'h0)
    ) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_stall_fetch    (i_stall_fetch),
        .i_ex_valid       (i_ex_valid),
        .i_ex_is_branch   (i_ex_is_branch),
        .i_ex_pc          (i_ex_pc),
        .i_ex_taken       (i_ex_taken),
        .i_ex_target      (i_ex_target),
        .i_ex_pred_taken  (i_ex_pred_taken),
        .i_ex_pred_target (i_ex_pred_target),
        .o_pc             (o_pc),
        .o_pred_taken     (o_pred_taken),
        .o_pred_target    (o_pred_target),
        .o_stall_decode   (o_stall_decode),
        .o_flush_decode   (o_flush_decode),
`ifdef FETCH_CTRL_PERF_EN
        .o_branch_cnt     (o_branch_cnt),
        .o_mispred_cnt    (o_mispred_cnt),
`endif
        .o_flush_execute  (o_flush_execute)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_stall_fetch    = 1'b0;
        i_ex_valid       = 1'b0;
        i_ex_is_branch   = 1'b0;
        i_ex_pc          = '0;
        i_ex_taken       = 1'b0;
        i_ex_target      = '0;
        i_ex_pred_taken  = 1'b0;
        i_ex_pred_target = '0;
    endtask

    task automatic drive_br(input logic [31:0] pc,
                            input logic tk,
                            input logic [31:0] tgt,
                            input logic pt,
                            input logic [31:0] ptgt);
        i_ex_valid       = 1'b1;
        i_ex_is_branch   = 1'b1;
        i_ex_pc          = pc;
        i_ex_taken       = tk;
        i_ex_target      = tgt;
        i_ex_pred_taken  = pt;
        i_ex_pred_target = ptgt;
    endtask

    // Force fetch to addr via a mispredicted jump at a spare slot.
    task automatic redirect_to(input logic [31:0] addr);
        drive_br(32'h0000_03F0, 1'b1, addr, 1'b0, 32'h0);
        tick();
        idle();
        #1;
    endtask

    task automatic test_reset();
        idle();
        #2;
        n_tests++;
        if (o_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pc got=%h exp=0", o_pc);
        end
        n_tests++;
        if ({o_pred_taken, o_pred_target, o_stall_decode,
             o_flush_decode, o_flush_execute} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs got=%b/%h/%b%b%b exp=0",
                     o_pred_taken, o_pred_target, o_stall_decode,
                     o_flush_decode, o_flush_execute);
        end
        tick();
        i_reset = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp = 32'(k * 4);
            n_tests++;
            if (o_pc !== exp || o_flush_decode !== 1'b0 ||
                o_flush_execute !== 1'b0 ||
                o_stall_decode !== 1'b0) begin
                n_fail++;
                $display("FAIL seq_%0d got=%h fl=%b%b st=%b exp=%h",
                         k, o_pc, o_flush_decode, o_flush_execute,
                         o_stall_decode, exp);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        i_stall_fetch = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (o_pc !== 32'h10 || o_stall_decode !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_%0d got=%h st=%b exp=10 st=1",
                         k, o_pc, o_stall_decode);
            end
            tick();
        end
        i_stall_fetch = 1'b0;
        #1;
        n_tests++;
        if (o_pc !== 32'h10 || o_stall_decode !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release got=%h st=%b exp=10 st=0",
                     o_pc, o_stall_decode);
        end
        tick();
        n_tests++;
        if (o_pc !== 32'h14) begin
            n_fail++;
            $display("FAIL stall_after got=%h exp=14", o_pc);
        end
    endtask

    task automatic test_branch_taken();
        drive_br(32'h20, 1'b1, 32'h80, 1'b0, 32'h0);
        #1;
        n_tests++;
        if (o_flush_decode !== 1'b1 || o_flush_execute !== 1'b1) begin
            n_fail++;
            $display("FAIL taken_flush got=%b%b exp=11",
                     o_flush_decode, o_flush_execute);
        end
        tick();
        idle();
        #1;
        n_tests++;
        if (o_pc !== 32'h80 || o_flush_decode !== 1'b0) begin
            n_fail++;
            $display("FAIL taken_redir got=%h fl=%b exp=80 fl=0",
                     o_pc, o_flush_decode);
        end
        redirect_to(32'h20);
        n_tests++;
        if (o_pc !== 32'h20 || o_pred_taken !== 1'b1 ||
            o_pred_target !== 32'h80) begin
            n_fail++;
            $display("FAIL taken_pred got=%h/%b/%h exp=20/1/80",
                     o_pc, o_pred_taken, o_pred_target);
        end
        tick();
        n_tests++;
        if (o_pc !== 32'h80) begin
            n_fail++;
            $display("FAIL taken_follow got=%h exp=80", o_pc);
        end
    endtask

    task automatic test_not_taken();
        drive_br(32'h20, 1'b0, 32'h0, 1'b1, 32'h80);
        #1;
        n_tests++;
        if (o_flush_decode !== 1'b1) begin
            n_fail++;
            $display("FAIL nt_flush got=%b exp=1", o_flush_decode);
        end
        tick();
        idle();
        #1;
        n_tests++;
        if (o_pc !== 32'h24) begin
            n_fail++;
            $display("FAIL nt_redir got=%h exp=24", o_pc);
        end
        redirect_to(32'h20);
        n_tests++;
        if (o_pred_taken !== 1'b0 || o_pred_target !== 32'h80) begin
            n_fail++;
            $display("FAIL nt_pred got=%b/%h exp=0/80",
                     o_pred_taken, o_pred_target);
        end
        tick();
        n_tests++;
        if (o_pc !== 32'h24) begin
            n_fail++;
            $display("FAIL nt_follow got=%h exp=24", o_pc);
        end
        drive_br(32'h20, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_tests++;
        if (o_flush_decode !== 1'b0 || o_flush_execute !== 1'b0) begin
            n_fail++;
            $display("FAIL nt_correct got=%b%b exp=00",
                     o_flush_decode, o_flush_execute);
        end
        tick();
        idle();
        #1;
    endtask

    task automatic test_mispredict_stall();
        i_stall_fetch = 1'b1;
        drive_br(32'h40, 1'b1, 32'h200, 1'b0, 32'h0);
        #1;
        n_tests++;
        if (o_stall_decode !== 1'b0 || o_flush_decode !== 1'b1) begin
            n_fail++;
            $display("FAIL ms_ctrl got=st%b fl%b exp=st0 fl1",
                     o_stall_decode, o_flush_decode);
        end
        tick();
        i_ex_valid = 1'b0;
        #1;
        n_tests++;
        if (o_pc !== 32'h200 || o_stall_decode !== 1'b1) begin
            n_fail++;
            $display("FAIL ms_redir got=%h st=%b exp=200 st=1",
                     o_pc, o_stall_decode);
        end
        tick();
        n_tests++;
        if (o_pc !== 32'h200) begin
            n_fail++;
            $display("FAIL ms_hold got=%h exp=200", o_pc);
        end
        idle();
        #1;
    endtask

    task automatic test_aliasing();
        logic [31:0] alias_pc;
        alias_pc = 32'h20 + 32'(4 * N);
        redirect_to(alias_pc);
        n_tests++;
        if (o_pred_taken !== 1'b0 || o_pred_target !== 32'h0) begin
            n_fail++;
            $display("FAIL alias_miss got=%b/%h exp=0/0",
                     o_pred_taken, o_pred_target);
        end
        drive_br(alias_pc, 1'b1, 32'h500, 1'b0, 32'h0);
        tick();
        idle();
        #1;
        n_tests++;
        if (o_pc !== 32'h500) begin
            n_fail++;
            $display("FAIL alias_redir got=%h exp=500", o_pc);
        end
        redirect_to(alias_pc);
        n_tests++;
        if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h500) begin
            n_fail++;
            $display("FAIL alias_hit got=%b/%h exp=1/500",
                     o_pred_taken, o_pred_target);
        end
        redirect_to(32'h20);
        n_tests++;
        if (o_pred_taken !== 1'b0 || o_pred_target !== 32'h0) begin
            n_fail++;
            $display("FAIL alias_evict got=%b/%h exp=0/0",
                     o_pred_taken, o_pred_target);
        end
    endtask

    task automatic test_wrap();
        redirect_to(32'hFFFF_FFFC);
        tick();
        n_tests++;
        if (o_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_seq got=%h exp=0", o_pc);
        end
        drive_br(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h1234);
        tick();
        idle();
        #1;
        n_tests++;
        if (o_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_redir got=%h exp=0", o_pc);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        tick();
        #2;
        i_reset = 1'b0;
        #1;
        n_tests++;
        if (o_pc !== 32'h0 || o_pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_pc got=%h/%b exp=0/0",
                     o_pc, o_pred_taken);
        end
        tick();
        i_reset = 1'b1;
        #1;
        n_tests++;
        if (o_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_hold got=%h exp=0", o_pc);
        end
        tick();
        n_tests++;
        if (o_pc !== 32'h4) begin
            n_fail++;
            $display("FAIL rstmid_resume got=%h exp=4", o_pc);
        end
        redirect_to(32'h120);
        n_tests++;
        if (o_pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_clear got=%b exp=0", o_pred_taken);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        logic        mvalid [N];
        logic [29:0] mword [N];
        logic        mtaken [N];
        logic [31:0] mtarget [N];
        logic        mknown [N];
        logic [31:0] m_pc;
        logic [31:0] exp_tgt;
        logic [31:0] nxt;
        logic        hit;
        logic        exp_pt;
        logic        tknown;
        logic        res;
        logic        misp;
        logic        exp_st;
        int          idx;
        int          wi;
        int          m_br;
        int          m_mis;
        pool = '{32'h20, 32'h120, 32'h40, 32'h44,
                 32'h140, 32'h80, 32'hFFFF_FFFC, 32'h1000};
        for (int e = 0; e < N; e++) begin
            mvalid[e]  = 1'b0;
            mword[e]   = '0;
            mtaken[e]  = 1'b0;
            mtarget[e] = '0;
            mknown[e]  = 1'b0;
        end
        m_br  = 0;
        m_mis = 0;
        idle();
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        m_pc = 32'h0;
        for (int c = 0; c < 400; c++) begin
            i_stall_fetch   = ($urandom_range(0, 3) == 0);
            i_ex_valid      = 1'($urandom_range(0, 1));
            i_ex_is_branch  = ($urandom_range(0, 9) < 7);
            i_ex_pc         = pool[$urandom_range(0, 7)];
            i_ex_taken      = 1'($urandom_range(0, 1));
            i_ex_target     = pool[$urandom_range(0, 7)];
            i_ex_pred_taken = 1'($urandom_range(0, 1));
            i_ex_pred_target = $urandom_range(0, 1) ? i_ex_target
                               : pool[$urandom_range(0, 7)];
            #1;
            idx    = int'(m_pc[31:2]) % N;
            hit    = mvalid[idx] && (mword[idx] == m_pc[31:2]);
            exp_pt = hit && mtaken[idx];
            tknown = !hit || mknown[idx];
            exp_tgt = hit ? mtarget[idx] : 32'h0;
            res    = i_ex_valid && i_ex_is_branch;
            misp   = res && ((i_ex_taken != i_ex_pred_taken) ||
                     (i_ex_taken && i_ex_target != i_ex_pred_target));
            exp_st = i_stall_fetch && !misp;
            n_tests++;
            if (o_pc !== m_pc || o_pred_taken !== exp_pt) begin
                n_fail++;
                $display("FAIL rnd_pc c=%0d got=%h/%b exp=%h/%b",
                         c, o_pc, o_pred_taken, m_pc, exp_pt);
            end
            if (tknown) begin
                n_tests++;
                if (o_pred_target !== exp_tgt) begin
                    n_fail++;
                    $display("FAIL rnd_tgt c=%0d got=%h exp=%h",
                             c, o_pred_target, exp_tgt);
                end
            end
            n_tests++;
            if (o_flush_decode !== misp || o_flush_execute !== misp ||
                o_stall_decode !== exp_st) begin
                n_fail++;
                $display("FAIL rnd_ctl c=%0d got=%b%b%b exp=%b%b%b",
                         c, o_flush_decode, o_flush_execute,
                         o_stall_decode, misp, misp, exp_st);
            end
            if (misp) begin
                nxt = i_ex_taken ? i_ex_target : i_ex_pc + 32'd4;
            end else if (i_stall_fetch) begin
                nxt = m_pc;
            end else if (exp_pt) begin
                nxt = mtarget[idx];
            end else begin
                nxt = m_pc + 32'd4;
            end
            if (res) begin
                wi = int'(i_ex_pc[31:2]) % N;
                mvalid[wi] = 1'b1;
                mword[wi]  = i_ex_pc[31:2];
                mtaken[wi] = i_ex_taken;
                if (i_ex_taken) begin
                    mtarget[wi] = i_ex_target;
                    mknown[wi]  = 1'b1;
                end
                m_br++;
            end
            if (misp) begin
                m_mis++;
            end
            m_pc = nxt;
            @(posedge i_clk);
            #1;
        end
`ifdef FETCH_CTRL_PERF_EN
        n_tests++;
        if (o_branch_cnt !== 32'(m_br) ||
            o_mispred_cnt !== 32'(m_mis)) begin
            n_fail++;
            $display("FAIL perf_cnt got=%0d/%0d exp=%0d/%0d",
                     o_branch_cnt, o_mispred_cnt, m_br, m_mis);
        end
`else
        if (m_br < m_mis) begin
            $display("note: counts inconsistent %0d %0d", m_br, m_mis);
        end
`endif
        idle();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_taken();
        test_not_taken();
        test_mispredict_stall();
        test_aliasing();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage sequencer for the 5-stage pipelined core. Owns the program counter, the 1-bit branch history/target table, and the stall/flush controls of the synchronous instruction memory. Predicts taken branches/jumps at fetch, resolves them against the EX-stage outcome, and redirects with pipeline flushes on mispredict.

## Interface
- BHT_ENTRIES, 64, number of direct-mapped predictor entries (power of 2, ≥ 4)
- RESET_PC, 32'h0000_0000, PC value held in reset

- i_clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-low
- i_stall_fetch  in  1  hazard unit requests hold of PC and decode register (load-use)
- i_ex_valid  in  1  EX stage holds a valid instruction this cycle
- i_ex_is_branch  in  1  EX instruction is a conditional branch, JAL or JALR
- i_ex_pc  in  32  PC of EX instruction
- i_ex_taken  in  1  resolved direction
- i_ex_target  in  32  resolved target address
- i_ex_pred_taken  in  1  prediction carried down the pipe with this instruction
- i_ex_pred_target  in  32  predicted target carried down the pipe
- o_pc  out  32  fetch address to instruction memory
- o_pred_taken  out  1  prediction for o_pc, to be pipelined
- o_pred_target  out  32  predicted target for o_pc, to be pipelined
- o_stall_decode  out  1  hold instruction memory output register
- o_flush_decode  out  1  zero instruction memory output register
- o_flush_execute  out  1  squash ID/EX register

## Operation
- Table entry: valid, tag = pc[31:IDX+2], taken bit, 32-bit target; index = pc[IDX+1:2], IDX = log2(BHT_ENTRIES).
- Lookup combinational on o_pc: hit = valid & tag match; o_pred_taken = hit & taken bit; o_pred_target = entry target (0 when no hit).
- Resolve = i_ex_valid & i_ex_is_branch. Mispredict = resolve & ((i_ex_taken ≠ i_ex_pred_taken) | (i_ex_taken & i_ex_pred_taken & i_ex_target ≠ i_ex_pred_target)).
- Redirect address = i_ex_taken ? i_ex_target : i_ex_pc + 4 (32-bit wrap).
- Next PC priority: mispredict → redirect address; else i_stall_fetch → hold; else o_pred_taken → o_pred_target; else o_pc + 4 (wraps at 2^32).
- o_flush_decode = o_flush_execute = mispredict. o_stall_decode = i_stall_fetch & ~mispredict (memory evaluates stall before flush, so stall must drop on redirect).
- Table update on resolve (mispredicted or not): valid←1, tag←i_ex_pc tag, taken←i_ex_taken; target←i_ex_target only when i_ex_taken, else unchanged. Non-branches never allocate.
- Reset: o_pc = RESET_PC, all valid bits 0, outputs o_pred_taken = 0, o_pred_target = 0, o_stall_decode = 0, flushes 0 (i_ex_valid must be low).

## Timing
- PC register updates on posedge i_clk; instruction for o_pc appears at memory output one cycle later.
- Mispredict penalty: 2 cycles (instructions in IF/ID and ID/EX squashed); correct-path PC on o_pc the cycle after mispredict.
- Table write on same edge as PC update; lookup in the same cycle at the same index sees the pre-write entry (no bypass).
- Reset asserted mid-operation: PC and valid bits clear immediately; counters clear; deassertion resumes fetch from RESET_PC.

## Configuration
- FETCH_CTRL_PERF_EN defined: extra outputs o_branch_cnt[31:0] (increments per resolve) and o_mispred_cnt[31:0] (increments per mispredict); wrap at 2^32; reset to 0; frozen while i_stall_fetch & ~mispredict is not relevant—counts every resolving cycle regardless of stall.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Package fetch_pkg: bht_entry_t struct (valid, tag, taken, target), XLEN = 32, INSTR_BYTES = 4, default RESET_PC.
- One sub-module fetch_bht: table storage, combinational lookup port, synchronous write port, async clear of valid bits.

## Test plan
- Reset release, no branches, no stall → o_pc 0x0, 0x4, 0x8, 0xC on successive cycles; all flush/stall outputs 0.
- i_stall_fetch high 2 cycles at o_pc = 0x10 → o_pc holds 0x10, o_stall_decode = 1 both cycles, then 0x14.
- Resolve branch pc 0x20, taken to 0x80, pred 0 → flushes 1 for one cycle, next o_pc = 0x80; later fetch of 0x20 gives o_pred_taken = 1, o_pred_target = 0x80, next o_pc = 0x80.
- Resolve pc 0x20 not-taken with pred 1 → redirect o_pc = 0x24, entry taken bit cleared, next fetch of 0x20 predicts not-taken.
- Mispredict coincident with i_stall_fetch = 1 → o_stall_decode = 0, o_flush_decode = 1, PC takes redirect.
- Aliasing: pc 0x20 and 0x20+4·BHT_ENTRIES → second lookup misses (tag mismatch) until its own resolve overwrites the entry.
